module_keypad_scan_debounce: RTL
================================

// Module: module_keypad_scan_debounce
// PURPOSE
//  Parametrised matrix-keypad scanner with frame-level debounce; successor to the fixed 4x4 anti-bounce block.
//  Drives one column low at a time and reads active-low rows through a 2-FF synchroniser.
//  Classifies each complete scan frame as NONE, SINGLE(code) or MULTI, and confirms a result only after DB_FRAMES identical frames.
//  Sits between the keypad pins and the input/command logic, which consumes key_code on the key_valid pulse.
// PARAMETERS
//  ROWS       4       number of row inputs (>=1)
//  COLS       4       number of column outputs (>=1)
//  SCAN_DIV   27000   clk cycles per column step (1 ms at 27 MHz); must be >=4
//  DB_FRAMES  10      consecutive identical frames required to confirm a press or release (>=1)
//  CODE_W     $clog2(ROWS*COLS), minimum 1; derived localparam, not overridable
// PORTS
//  clk          in   1        system clock (27 MHz)
//  rst          in   1        asynchronous reset, active-low
//  rows_in      in   ROWS     keypad rows, active-low, pulled up externally, asynchronous
//  cols_out     out  COLS     column drive, exactly one bit low at any time
//  key_code     out  CODE_W   confirmed key = row*COLS + col; held until the next confirmed single key
//  key_valid    out  1        one-cycle pulse when a new single key is confirmed
//  key_pressed  out  1        high while a confirmed key is held
//  multi_key    out  1        high while a MULTI frame class is confirmed
// BEHAVIOUR
//  Reset (rst=0, async): cols_out={COLS{1}} with bit0=0; col_idx=0; div_cnt=0; sync FFs=1s.
//   Also: frame accumulator cleared; stable_cnt=0; prev class=NONE; tracker=RELEASED.
//   All outputs key_code/key_valid/key_pressed/multi_key are 0.
//  Scan: div_cnt counts 0..SCAN_DIV-1. At terminal count:
//   - sample synced rows into the accumulator for col_idx (bit r set when row r reads low);
//   - col_idx advances, wrapping COLS-1 -> 0;
//   - cols_out updates on the same edge.
//  Frame end = terminal count with col_idx=COLS-1; one frame = COLS*SCAN_DIV cycles.
//   The accumulator is cleared for the next frame on that same edge.
//  Classify: 0 set bits -> NONE; exactly 1 -> SINGLE(row*COLS+col); >=2 -> MULTI.
//   Same row/column combinations are counted; no ghost-key suppression.
//  Stability: if class (including code) equals prev, stable_cnt++, saturating at DB_FRAMES; else stable_cnt=1.
//   prev is then set to class. Evaluation occurs on the frame-end edge; outputs update 1 cycle later.
//  Tracker FSM:
//   RELEASED: stable SINGLE(c) reaches DB_FRAMES -> PRESSED: key_code=c, key_valid=1 for 1 cycle, key_pressed=1.
//     Stable MULTI -> multi_key=1 and stay RELEASED; no key_valid.
//   PRESSED: stable NONE reaches DB_FRAMES -> RELEASED: key_pressed=0, multi_key=0, key_code retained.
//     Stable different SINGLE or MULTI -> multi_key follows (1 for MULTI, 0 for SINGLE).
//     No new key_valid until release is confirmed (no roll-over).
//   Any stable NONE clears multi_key.
//  key_valid fires only on the RELEASED->PRESSED transition, at most once per confirmed press.
//  A bounce shorter than one frame resets stable_cnt. Confirmation latency from a clean press:
//   DB_FRAMES..DB_FRAMES+1 frames, plus 3 cycles.
//  Reset mid-scan or mid-press: immediate return to the reset state, no key_valid emitted.
//   The scan restarts at column 0.
// TESTING (ROWS=COLS=4, SCAN_DIV=4, DB_FRAMES=3; frame=16 cycles)
//  Bench keypad model: rows_in[r]=0 iff key(r,c) pressed and cols_out[c]==0; otherwise 1.
//  1 Reset: hold rst=0 for 5 cycles -> cols_out=4'b1110; all outputs 0. Check one-hot-low walk, 4 cycles/column.
//  2 Clean press (1,2): within 4 frames + 3 cycles -> one key_valid pulse, key_code=6, key_pressed=1.
//    Hold 10 frames -> no further pulses. Release -> key_pressed=0 after 3-4 frames; key_code stays 6.
//  3 Bounce: toggle key (0,0) every 8 cycles for 6 frames -> no key_valid. Then hold stable -> key_valid, key_code=0.
//  4 Multi: press (0,0)+(3,3) -> multi_key=1 after 3-4 frames, no key_valid. Release both -> multi_key=0.
//  5 Roll-over: hold (2,1) confirmed (code 9), then add (2,3) and release (2,1) -> no new key_valid.
//    Full release, then press (2,3) -> key_valid, key_code=11.
//  6 Async reset while key_pressed=1: rst low mid-cycle -> outputs 0 immediately.
//    Key still held after rst release -> key_valid re-confirmed after DB_FRAMES frames.

Source files
------------

// File: rtl/module_keypad_scan_debounce.sv
// Matrix keypad scanner: walks a low column across the keypad, classifies each scan frame
// as none/single/multi, and confirms press and release only after DB_FRAMES identical frames.
module module_keypad_scan_debounce #(
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int SCAN_DIV  = 27000,
   parameter int DB_FRAMES = 10,
   localparam int CODE_W   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ROWS-1:0]   rows_in,
   output logic [COLS-1:0]   cols_out,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   output logic              key_pressed,
   output logic              multi_key
);

   localparam int KEYS  = ROWS * COLS;
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DB_FRAMES + 1);
   localparam logic [COLS-1:0] COLS_RST = ~(COLS'(1));

   typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_e;
   typedef enum logic {ST_RELEASED, ST_PRESSED} trk_e;

   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [COL_W-1:0]  col_idx_q, col_idx_d;
   logic [COLS-1:0]   cols_q, cols_d;
   logic [ROWS-1:0]   sync1_q, sync1_d;
   logic [ROWS-1:0]   sync2_q, sync2_d;
   logic [KEYS-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]  stable_cnt_q, stable_cnt_d;
   cls_e              prev_kind_q, prev_kind_d;
   logic [CODE_W-1:0] prev_code_q, prev_code_d;
   logic              eval_q, eval_d;
   trk_e              state_q, state_d;
   logic [CODE_W-1:0] key_code_q, key_code_d;
   logic              key_valid_q, key_valid_d;
   logic              key_pressed_q, key_pressed_d;
   logic              multi_key_q, multi_key_d;

   logic              tc;
   logic              frame_end;
   logic [COL_W-1:0]  col_next;
   logic [KEYS-1:0]   frame_vec;
   logic [1:0]        n_set;
   logic [CODE_W-1:0] cls_code;
   cls_e              cls_kind;
   logic              same_cls;
   logic              stable_hit;

   // Column walk, row sampling into the frame accumulator, and per-frame classification
   always_comb begin
      tc        = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
      frame_end = tc && (col_idx_q == COL_W'(COLS - 1));
      col_next  = frame_end ? '0 : col_idx_q + COL_W'(1);
      div_cnt_d = tc ? '0 : div_cnt_q + DIV_W'(1);
      col_idx_d = tc ? col_next : col_idx_q;
      sync1_d   = rows_in;
      sync2_d   = sync1_q;

      cols_d = cols_q;
      if (tc) begin
         for (int c = 0; c < COLS; c++) begin
            cols_d[c] = (col_next != COL_W'(c));
         end
      end

      frame_vec = acc_q;
      if (tc) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               if ((col_idx_q == COL_W'(c)) && !sync2_q[r]) begin
                  frame_vec[r*COLS + c] = 1'b1;
               end
            end
         end
      end
      acc_d = frame_end ? '0 : frame_vec;

      n_set    = 2'd0;
      cls_code = '0;
      for (int i = 0; i < KEYS; i++) begin
         if (frame_vec[i]) begin
            if (n_set == 2'd0) begin
               cls_code = CODE_W'(i);
            end
            if (n_set != 2'd2) begin
               n_set = n_set + 2'd1;
            end
         end
      end
      cls_kind = (n_set == 2'd0) ? CLS_NONE : (n_set == 2'd1) ? CLS_SINGLE : CLS_MULTI;
      if (cls_kind != CLS_SINGLE) begin
         cls_code = '0;
      end
      same_cls = (cls_kind == prev_kind_q) && (cls_code == prev_code_q);

      stable_cnt_d = stable_cnt_q;
      prev_kind_d  = prev_kind_q;
      prev_code_d  = prev_code_q;
      if (frame_end) begin
         if (!same_cls) begin
            stable_cnt_d = CNT_W'(1);
         end else if (stable_cnt_q != CNT_W'(DB_FRAMES)) begin
            stable_cnt_d = stable_cnt_q + CNT_W'(1);
         end
         prev_kind_d = cls_kind;
         prev_code_d = cls_code;
      end
      eval_d = frame_end;
   end

   // Press/release tracker, acting one cycle after each frame evaluation
   always_comb begin
      state_d       = state_q;
      key_code_d    = key_code_q;
      key_valid_d   = 1'b0;
      key_pressed_d = key_pressed_q;
      multi_key_d   = multi_key_q;
      stable_hit    = eval_q && (stable_cnt_q == CNT_W'(DB_FRAMES));
      if (stable_hit) begin
         case (state_q)
            ST_RELEASED: begin
               case (prev_kind_q)
                  CLS_SINGLE: begin
                     state_d       = ST_PRESSED;
                     key_code_d    = prev_code_q;
                     key_valid_d   = 1'b1;
                     key_pressed_d = 1'b1;
                     multi_key_d   = 1'b0;
                  end
                  CLS_MULTI: multi_key_d = 1'b1;
                  default:   multi_key_d = 1'b0;
               endcase
            end
            default: begin
               case (prev_kind_q)
                  CLS_NONE: begin
                     state_d       = ST_RELEASED;
                     key_pressed_d = 1'b0;
                     multi_key_d   = 1'b0;
                  end
                  CLS_MULTI: multi_key_d = 1'b1;
                  default:   multi_key_d = 1'b0;
               endcase
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt_q     <= '0;
         col_idx_q     <= '0;
         cols_q        <= COLS_RST;
         sync1_q       <= '1;
         sync2_q       <= '1;
         acc_q         <= '0;
         stable_cnt_q  <= '0;
         prev_kind_q   <= CLS_NONE;
         prev_code_q   <= '0;
         eval_q        <= 1'b0;
         state_q       <= ST_RELEASED;
         key_code_q    <= '0;
         key_valid_q   <= 1'b0;
         key_pressed_q <= 1'b0;
         multi_key_q   <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         col_idx_q     <= col_idx_d;
         cols_q        <= cols_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         acc_q         <= acc_d;
         stable_cnt_q  <= stable_cnt_d;
         prev_kind_q   <= prev_kind_d;
         prev_code_q   <= prev_code_d;
         eval_q        <= eval_d;
         state_q       <= state_d;
         key_code_q    <= key_code_d;
         key_valid_q   <= key_valid_d;
         key_pressed_q <= key_pressed_d;
         multi_key_q   <= multi_key_d;
      end
   end

   assign cols_out    = cols_q;
   assign key_code    = key_code_q;
   assign key_valid   = key_valid_q;
   assign key_pressed = key_pressed_q;
   assign multi_key   = multi_key_q;

endmodule
